// File: rtl/ptmch_spi_rx.sv
// ptmch_spi_rx: SPI slave receiver for the pattern-match trigger path.
// Oversamples asynchronous SPI_CS/SPI_CLK/SPI_MOSI in the CLK160M domain,
// deserializes ADDR_W+DATA_W bit write frames (MSB first, mode 0) and issues
// one-cycle register-write strobes. Short/long frames pulse FRM_ERR and bump
// a saturating error counter.
// Optional build macro: PTMCH_SPI_GLITCH_FILTER_EN adds a 3-tap majority
// filter on SPI_CLK and SPI_CS (rejects 1-cycle pulses, +1 cycle latency).
module ptmch_spi_rx #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 CLK160M,
    input  logic                 RESET_N,
    input  logic                 SPI_CS,
    input  logic                 SPI_CLK,
    input  logic                 SPI_MOSI,
    output logic                 WR_EN,
    output logic [ADDR_W-1:0]    WR_ADDR,
    output logic [DATA_W-1:0]    WR_DATA,
    output logic                 FRM_ERR,
    output logic [ERR_CNT_W-1:0] ERR_CNT
);

    localparam int FRAME_LEN = ADDR_W + DATA_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);
`ifdef PTMCH_SPI_GLITCH_FILTER_EN
    localparam int TAP_N = 5;   // 2 sync flops + 3 majority taps
`else
    localparam int TAP_N = 3;   // 2 sync flops + 1 edge-detect delay flop
`endif

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2,
        DONE      = 2'd3
    } state_t;

    // Pins that get edge detection: index 0 = SPI_CS, index 1 = SPI_CLK
    logic [1:0]       edge_pins;
    logic [TAP_N-1:0] tap_reg [2];
    logic [1:0]       lvl_now;
    logic [1:0]       lvl_prev;
    logic [1:0]       mosi_reg;

    assign edge_pins = {SPI_CLK, SPI_CS};

`ifdef PTMCH_SPI_GLITCH_FILTER_EN
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cond
            // Synchronizer plus delay taps for one control pin
            always_ff @(posedge CLK160M) begin
                if (!RESET_N) begin
                    tap_reg[gi] <= '0;
                end else begin
                    tap_reg[gi] <= {tap_reg[gi][TAP_N-2:0], edge_pins[gi]};
                end
            end
`ifdef PTMCH_SPI_GLITCH_FILTER_EN
            // Majority of three consecutive samples; the previous level is the
            // same vote one cycle older, so edges come from filtered levels.
            assign lvl_now[gi]  = maj3(tap_reg[gi][1], tap_reg[gi][2], tap_reg[gi][3]);
            assign lvl_prev[gi] = maj3(tap_reg[gi][2], tap_reg[gi][3], tap_reg[gi][4]);
`else
            assign lvl_now[gi]  = tap_reg[gi][1];
            assign lvl_prev[gi] = tap_reg[gi][2];
`endif
        end
    endgenerate

    // MOSI only needs plain synchronization; it is stable around SCLK rising edges
    always_ff @(posedge CLK160M) begin
        if (!RESET_N) begin
            mosi_reg <= '0;
        end else begin
            mosi_reg <= {mosi_reg[0], SPI_MOSI};
        end
    end

    logic mosi_s;
    logic sclk_rise;
    logic cs_act;
    logic cs_end;      // chip select released (cs_act falling)

    assign mosi_s    = mosi_reg[1];
    assign sclk_rise = lvl_now[1] & ~lvl_prev[1];
    assign cs_act    = ~lvl_now[0];
    assign cs_end    = lvl_now[0] & ~lvl_prev[0];

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [FRAME_LEN-1:0]   shift_reg, shift_next;
    logic                   long_reg, long_next;
    logic                   wr_en_reg, wr_en_next;
    logic                   frm_err_reg, frm_err_next;
    logic [ADDR_W-1:0]      addr_reg, addr_next;
    logic [DATA_W-1:0]      data_reg, data_next;
    logic [ERR_CNT_W-1:0]   err_cnt_reg, err_cnt_next;

    // Frame FSM state and output registers
    always_ff @(posedge CLK160M) begin
        if (!RESET_N) begin
            state_reg   <= WAIT_IDLE;
            cnt_reg     <= '0;
            shift_reg   <= '0;
            long_reg    <= 1'b0;
            wr_en_reg   <= 1'b0;
            frm_err_reg <= 1'b0;
            addr_reg    <= '0;
            data_reg    <= '0;
            err_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            shift_reg   <= shift_next;
            long_reg    <= long_next;
            wr_en_reg   <= wr_en_next;
            frm_err_reg <= frm_err_next;
            addr_reg    <= addr_next;
            data_reg    <= data_next;
            err_cnt_reg <= err_cnt_next;
        end
    end

    // Next-state, deserializer and strobe generation
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        shift_next   = shift_reg;
        long_next    = long_reg;
        wr_en_next   = 1'b0;
        frm_err_next = 1'b0;
        addr_next    = addr_reg;
        data_next    = data_reg;
        case (state_reg)
            WAIT_IDLE: begin
                // Drop whatever frame was in flight until CS is seen released
                if (!cs_act) state_next = IDLE;
            end
            IDLE: begin
                if (cs_act) begin
                    cnt_next   = '0;
                    shift_next = '0;
                    long_next  = 1'b0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // Final bit wins over a simultaneous CS release
                if (sclk_rise && cnt_reg == LAST_BIT) begin
                    shift_next = {shift_reg[FRAME_LEN-2:0], mosi_s};
                    cnt_next   = cnt_reg + CNT_W'(1);
                    wr_en_next = 1'b1;
                    addr_next  = shift_next[FRAME_LEN-1:DATA_W];
                    data_next  = shift_next[DATA_W-1:0];
                    state_next = DONE;
                end else if (cs_end) begin
                    frm_err_next = 1'b1;
                    state_next   = IDLE;
                end else if (sclk_rise) begin
                    shift_next = {shift_reg[FRAME_LEN-2:0], mosi_s};
                    cnt_next   = cnt_reg + CNT_W'(1);
                end
            end
            DONE: begin
                if (!cs_act) begin
                    state_next = IDLE;
                end else if (sclk_rise && !long_reg) begin
                    // Write already issued; flag the overrun once per frame
                    long_next    = 1'b1;
                    frm_err_next = 1'b1;
                end
            end
            default: state_next = WAIT_IDLE;
        endcase
        err_cnt_next = err_cnt_reg;
        if (frm_err_next && err_cnt_reg != {ERR_CNT_W{1'b1}}) begin
            err_cnt_next = err_cnt_reg + ERR_CNT_W'(1);
        end
    end

    assign WR_EN   = wr_en_reg;
    assign FRM_ERR = frm_err_reg;
    assign WR_ADDR = addr_reg;
    assign WR_DATA = data_reg;
    assign ERR_CNT = err_cnt_reg;

endmodule
